// File: rtl/screen_fetch_arbiter.sv
// rtl/screen_fetch_arbiter.sv - screen RAM read-port arbiter with double-buffered row prefetch
module screen_fetch_arbiter #(
    parameter logic [10:0] BASE_ADDR    = 11'h200,
    parameter int          STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        row_start,
    input  logic [4:0]  row_idx,
    input  logic        line_swap,
    input  logic [4:0]  pix_x,
    output logic [7:0]  pix_data,
    input  logic        cpu_rd_req,
    input  logic [10:0] cpu_rd_addr,
    output logic        cpu_rd_ack,
    output logic [7:0]  cpu_rd_data,
    output logic        ram_rd_en,
    output logic [10:0] ram_rd_addr,
    input  logic [7:0]  ram_rd_data,
    output logic        fetch_busy,
    output logic        back_ready,
    output logic        underrun,
    output logic        overrun
);

    localparam int WW = $clog2(STARVE_LIMIT + 1);
    localparam logic [WW-1:0] LIMIT = WW'(STARVE_LIMIT);

    typedef enum logic {IDLE, FETCH} state_t;

    state_t          state, next_state;
    logic [4:0]      col, row;
    logic [WW-1:0]   wait_cnt;
    logic            disp_bank;
    logic            cpu_issue, fetch_issue;
    logic [10:0]     fetch_addr;

    // issue pipeline: owner tag, column and "last column of an uninterrupted row"
    logic            p_valid, p_cpu, p_last;
    logic [4:0]      p_col;

    // bank selects the upper half; the back bank is always the one not on display
    logic [7:0]      line_buf [64];

    assign fetch_addr = BASE_ADDR + {1'b0, row, col};
    assign fetch_busy = (state == FETCH);

    // slot arbitration: CPU owns IDLE; in FETCH it only wins once starved for LIMIT cycles
    always_comb begin
        next_state  = state;
        ram_rd_en   = 1'b0;
        ram_rd_addr = cpu_rd_addr;
        cpu_issue   = 1'b0;
        fetch_issue = 1'b0;
        case (state)
            IDLE: begin
                ram_rd_en = cpu_rd_req;
                cpu_issue = cpu_rd_req;
                if (row_start) next_state = FETCH;
            end
            FETCH: begin
                ram_rd_en = 1'b1;
                if (cpu_rd_req && wait_cnt == LIMIT) begin
                    cpu_issue = 1'b1;
                end else begin
                    fetch_issue = 1'b1;
                    ram_rd_addr = fetch_addr;
                end
                if (!row_start && fetch_issue && col == 5'd31) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // control state, issue pipeline, read-data routing and status flags
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            wait_cnt    <= '0;
            disp_bank   <= 1'b0;
            p_valid     <= 1'b0;
            p_cpu       <= 1'b0;
            p_last      <= 1'b0;
            p_col       <= '0;
            cpu_rd_ack  <= 1'b0;
            cpu_rd_data <= '0;
            back_ready  <= 1'b0;
            underrun    <= 1'b0;
            overrun     <= 1'b0;
            pix_data    <= '0;
        end else begin
            state <= next_state;

            if (row_start) begin
                col <= '0;
                row <= row_idx;
                if (state == FETCH) overrun <= 1'b1;
            end else if (fetch_issue) begin
                col <= col + 5'd1;
            end

            if (fetch_issue && cpu_rd_req) wait_cnt <= wait_cnt + WW'(1);
            else                           wait_cnt <= '0;

            p_valid <= cpu_issue | fetch_issue;
            p_cpu   <= cpu_issue;
            p_col   <= col;
            // a restart on the final issue cancels completion of the old row
            p_last  <= fetch_issue && (col == 5'd31) && !row_start;

            cpu_rd_ack <= p_valid && p_cpu;
            if (p_valid && p_cpu) cpu_rd_data <= ram_rd_data;

            if (p_valid && !p_cpu && p_last) back_ready <= 1'b1;

            // swap uses the registered flag, so a same-cycle completion counts as not ready
            if (line_swap) begin
                if (back_ready) begin
                    disp_bank  <= ~disp_bank;
                    back_ready <= 1'b0;
                end else begin
                    underrun <= 1'b1;
                end
            end

            if (row_start) back_ready <= 1'b0;

            pix_data <= line_buf[{disp_bank, pix_x}];
        end
    end

    // fetched bytes land in whichever bank is currently the back bank
    always_ff @(posedge clk) begin
        if (p_valid && !p_cpu) line_buf[{~disp_bank, p_col}] <= ram_rd_data;
    end

endmodule

// File: tb/tb_screen_fetch_arbiter.sv
// tb/tb_screen_fetch_arbiter.sv - self-checking bench for screen_fetch_arbiter
module tb_screen_fetch_arbiter;

    localparam int STARVE_LIMIT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        row_start;
    logic [4:0]  row_idx;
    logic        line_swap;
    logic [4:0]  pix_x;
    logic [7:0]  pix_data;
    logic        cpu_rd_req;
    logic [10:0] cpu_rd_addr;
    logic        cpu_rd_ack;
    logic [7:0]  cpu_rd_data;
    logic        ram_rd_en;
    logic [10:0] ram_rd_addr;
    logic [7:0]  ram_rd_data;
    logic        fetch_busy;
    logic        back_ready;
    logic        underrun;
    logic        overrun;

    screen_fetch_arbiter #(.BASE_ADDR(11'h200), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset), .row_start(row_start), .row_idx(row_idx),
        .line_swap(line_swap), .pix_x(pix_x), .pix_data(pix_data),
        .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr), .cpu_rd_ack(cpu_rd_ack),
        .cpu_rd_data(cpu_rd_data), .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data), .fetch_busy(fetch_busy), .back_ready(back_ready),
        .underrun(underrun), .overrun(overrun)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [2048];
    always @(posedge clk) if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];

    typedef struct {
        logic [10:0] addr;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t       vecs [8];
    logic [7:0] sb [$];
    int         checks = 0;
    int         errors = 0;
    int         en_cnt = 0;
    int         ack_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // one clock: count read enables before the edge, then score any ack after it
    task automatic tick();
        logic [7:0] e;
        #1;
        if (ram_rd_en) en_cnt++;
        @(posedge clk);
        #1;
        if (cpu_rd_ack) begin
            ack_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack actual=1 required=0");
            end else begin
                e = sb.pop_front();
                if (cpu_rd_data !== e) begin
                    errors++;
                    $display("FAIL ack_data actual=%0h required=%0h", cpu_rd_data, e);
                end
            end
        end
    endtask

    task automatic sweep(input int r, input string name);
        for (int x = 0; x < 32; x++) begin
            pix_x = 5'(x);
            tick();
            chk(name, pix_data, 32'(8'(r ^ x)));
        end
    endtask

    task automatic swap();
        line_swap = 1'b1;
        tick();
        line_swap = 1'b0;
    endtask

    task automatic wait_ready(input string name, output int cyc);
        cyc = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (back_ready) begin
                cyc = i;
                break;
            end
        end
        if (cyc == 0) chk(name, 0, 1);
    endtask

    initial begin
        int ack_cyc, rdy_cyc;

        for (int a = 0; a < 2048; a++) mem[a] = 8'(a) ^ 8'h5A;
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                mem[32'h200 + r * 32 + c] = 8'(r ^ c);

        vecs[0] = '{11'h200, 8'h00};
        vecs[1] = '{11'h245, 8'h07};
        vecs[2] = '{11'h7FF, 8'hA5};
        vecs[3] = '{11'h000, 8'h5A};
        vecs[4] = '{11'h3FF, 8'h10};
        vecs[5] = '{11'h5E1, 8'h1E};
        vecs[6] = '{11'h5FF, 8'h00};
        vecs[7] = '{11'h600, 8'h5A};

        reset = 1'b0; row_start = 1'b0; row_idx = '0; line_swap = 1'b0;
        pix_x = '0; cpu_rd_req = 1'b0; cpu_rd_addr = '0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("rst_busy", fetch_busy, 0);
        chk("rst_ready", back_ready, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_pix", pix_data, 0);
        chk("rst_ack", cpu_rd_ack, 0);

        // single CPU reads in IDLE from the vector table
        for (int i = 0; i < 8; i++) begin
            cpu_rd_addr = vecs[i].addr;
            cpu_rd_req  = 1'b1;
            sb.push_back(vecs[i].exp_data);
            tick();
            cpu_rd_req = 1'b0;
            tick();
            chk("vec_ack", cpu_rd_ack, 1);
        end

        // row 5 prefetch, ready after 33 cycles, swap and sweep
        row_idx = 5'd5; row_start = 1'b1;
        tick();
        row_start = 1'b0;
        chk("t1_busy", fetch_busy, 1);
        repeat (32) tick();
        chk("t1_ready_early", back_ready, 0);
        tick();
        chk("t1_ready", back_ready, 1);
        chk("t1_idle", fetch_busy, 0);
        swap();
        chk("t1_ready_clr", back_ready, 0);
        sweep(5, "t1_pix");
        chk("t1_underrun", underrun, 0);

        // back-to-back CPU reads in IDLE
        en_cnt = 0; ack_cnt = 0;
        cpu_rd_req = 1'b1; cpu_rd_addr = 11'h010; sb.push_back(mem[11'h010]);
        tick();
        cpu_rd_addr = 11'h011; sb.push_back(mem[11'h011]);
        tick();
        chk("t2_ack1", ack_cnt, 1);
        cpu_rd_addr = 11'h012; sb.push_back(mem[11'h012]);
        tick();
        chk("t2_ack2", ack_cnt, 2);
        cpu_rd_req = 1'b0;
        tick();
        chk("t2_ack3", ack_cnt, 3);
        tick();
        chk("t2_en", en_cnt, 3);
        chk("t2_acks", ack_cnt, 3);

        // CPU starved during fetch gets its guaranteed slot
        row_idx = 5'd9; row_start = 1'b1;
        tick();
        row_start = 1'b0;
        cpu_rd_req = 1'b1; cpu_rd_addr = 11'h7FF; sb.push_back(mem[11'h7FF]);
        ack_cyc = 0; rdy_cyc = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (cpu_rd_ack && ack_cyc == 0) begin
                ack_cyc = i;
                cpu_rd_req = 1'b0;
            end
            if (back_ready) begin
                rdy_cyc = i;
                break;
            end
        end
        chk("t3_ack_cycle", ack_cyc, STARVE_LIMIT + 2);
        chk("t3_ready_cycle", rdy_cyc, 34);
        swap();
        sweep(9, "t3_pix");

        // swap with nothing ready
        pix_x = 5'd3;
        tick();
        swap();
        chk("t4_underrun", underrun, 1);
        tick();
        chk("t4_pix_hold", pix_data, 32'(8'(9 ^ 3)));
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("t4_underrun_rst", underrun, 0);
        chk("t4_pix_rst", pix_data, 0);

        // restart mid-row
        row_idx = 5'd3; row_start = 1'b1;
        tick();
        row_start = 1'b0;
        repeat (10) tick();
        row_idx = 5'd7; row_start = 1'b1;
        tick();
        row_start = 1'b0;
        chk("t5_overrun", overrun, 1);
        chk("t5_busy", fetch_busy, 1);
        wait_ready("t5_ready_timeout", rdy_cyc);
        chk("t5_ready_cycle", rdy_cyc, 33);
        swap();
        sweep(7, "t5_pix");

        // reset in the middle of a fetch with a CPU read in flight
        row_idx = 5'd2; row_start = 1'b1;
        tick();
        row_start = 1'b0;
        repeat (11) tick();
        cpu_rd_req = 1'b1; cpu_rd_addr = 11'h100;
        repeat (9) tick();
        reset = 1'b0; cpu_rd_req = 1'b0;
        tick();
        chk("t6_busy", fetch_busy, 0);
        chk("t6_ack", cpu_rd_ack, 0);
        chk("t6_ready", back_ready, 0);
        reset = 1'b1;
        tick();
        chk("t6_ack_after", cpu_rd_ack, 0);
        chk("t6_overrun", overrun, 0);

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
